rf80386_bus_arbiter: RTL and testbench

Shares the single 128-bit fta bus master port between two requesters: the data/load-store engine (D) and the instruction-bundle prefetcher (I). The block sits between the CPU core/prefetcher and the system bus. It picks one request per cycle, stamps it with an arbiter-owned transaction id, and tracks outstanding transactions in an owner table. Each response is routed back to the requester that issued it.

---
 rtl/fta_bus_pkg.sv | 25 ++
 rtl/rf80386_pkg.sv | 10 +
 rtl/rf80386_rr_arb2.sv | 12 +
 rtl/rf80386_bus_arbiter.sv | 101 ++++++++++
 tb/tb_rf80386_bus_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fta_bus_pkg.sv
// fta_bus_pkg: 128-bit fta bus command request/response types shared by bus masters and slaves.
package fta_bus_pkg;
  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [3:0] tranid;
  } fta_tranid_t;
  typedef struct packed {
    fta_tranid_t  tid;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_request128_t;
  typedef struct packed {
    fta_tranid_t  tid;
    logic         ack;
    logic         rty;
    logic         err;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;
endpackage

// File: rtl/rf80386_pkg.sv
// rf80386_pkg: core-wide types; holds the bus arbiter owner-table entry and tranid start value.
package rf80386_pkg;
  typedef enum logic {OWN_D = 1'b0, OWN_I = 1'b1} e_arb_owner;
  typedef struct packed {
    logic       valid;
    e_arb_owner owner;
    logic [7:0] age;
  } arb_entry_t;
  localparam logic [3:0] ARB_TRANID_FIRST = 4'd1;
endpackage

// File: rtl/rf80386_rr_arb2.sv
// rf80386_rr_arb2: two-way round-robin picker; a D write overrides fairness. grant = {i, d}.
module rf80386_rr_arb2 import rf80386_pkg::*; (
  input  logic       d_vld,
  input  logic       i_vld,
  input  logic       d_we,
  input  e_arb_owner last,
  output logic [1:0] grant
);
  logic d_win;
  assign d_win = d_vld && (!i_vld || d_we || last == OWN_I);
  assign grant = {i_vld && !d_win, d_win};
endmodule

// File: rtl/rf80386_bus_arbiter.sv
// rf80386_bus_arbiter: shares the fta master port between D and I, tags tranids, routes responses.
// Define RF80386_ARB_TIMEOUT_EN to retire stale entries with a synthesized rty response.
module rf80386_bus_arbiter import fta_bus_pkg::*, rf80386_pkg::*; #(
  parameter logic [5:0] CORENO     = 6'd1,
  parameter logic [2:0] CID        = 3'd1,
  parameter int         MAX_OUT    = 4,
  parameter int         TMO_CYCLES = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  fta_cmd_request128_t  d_req_i,
  output logic                 d_accept_o,
  output fta_cmd_response128_t d_resp_o,
  input  fta_cmd_request128_t  i_req_i,
  output logic                 i_accept_o,
  output fta_cmd_response128_t i_resp_o,
  output fta_cmd_request128_t  ftam_req,
  input  fta_cmd_response128_t ftam_resp,
  output logic                 busy_o
);
  arb_entry_t           tbl [16];
  logic [3:0]           tranid, cnt, rsp_idx, tmo_idx;
  e_arb_owner           last, tmo_owner;
  logic [1:0]           grant;
  logic                 can_issue, acc, rsp_hit, tmo_fire;
  fta_cmd_request128_t  sel_req;
  fta_cmd_response128_t tmo_resp;
  rf80386_rr_arb2 u_arb (
    .d_vld (d_req_i.cyc),
    .i_vld (i_req_i.cyc),
    .d_we  (d_req_i.we),
    .last  (last),
    .grant (grant)
  );
  assign can_issue  = rst_ni && cnt < 4'(MAX_OUT) && !tbl[tranid].valid;
  assign d_accept_o = can_issue && grant[0];
  assign i_accept_o = can_issue && grant[1];
  assign acc        = d_accept_o || i_accept_o;
  assign sel_req    = grant[0] ? d_req_i : i_req_i;
  assign rsp_idx    = ftam_resp.tid.tranid;
  assign rsp_hit    = (ftam_resp.ack || ftam_resp.rty) && ftam_resp.tid.core == CORENO &&
                      ftam_resp.tid.channel == CID && tbl[rsp_idx].valid;
`ifdef RF80386_ARB_TIMEOUT_EN
  // At most one entry expires per cycle; a real response to the same owner defers it a cycle.
  always_comb begin
    tmo_idx   = '0;
    tmo_owner = OWN_D;
    tmo_fire  = 1'b0;
    for (int k = 15; k >= 0; k--)
      if (tbl[k].valid && tbl[k].age >= 8'(TMO_CYCLES)) begin
        tmo_idx   = 4'(k);
        tmo_owner = tbl[k].owner;
        tmo_fire  = 1'b1;
      end
    if (rsp_hit && tbl[rsp_idx].owner == tmo_owner) tmo_fire = 1'b0;
    tmo_resp = '0;
    tmo_resp.tid.core    = CORENO;
    tmo_resp.tid.channel = CID;
    tmo_resp.tid.tranid  = tmo_idx;
    tmo_resp.rty         = 1'b1;
  end
`else
  assign tmo_idx   = '0;
  assign tmo_owner = OWN_D;
  assign tmo_fire  = 1'b0;
  assign tmo_resp  = '0;
`endif
  assign d_resp_o = rsp_hit && tbl[rsp_idx].owner == OWN_D ? ftam_resp :
                    tmo_fire && tmo_owner == OWN_D ? tmo_resp : '0;
  assign i_resp_o = rsp_hit && tbl[rsp_idx].owner == OWN_I ? ftam_resp :
                    tmo_fire && tmo_owner == OWN_I ? tmo_resp : '0;
  assign busy_o   = cnt != 4'd0 || ftam_req.cyc;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      ftam_req <= '0;
      tranid   <= ARB_TRANID_FIRST;
      cnt      <= '0;
      last     <= OWN_I;
      for (int k = 0; k < 16; k++) tbl[k] <= '0;
    end else begin
      ftam_req <= '0;
      if (acc) begin
        ftam_req             <= sel_req;
        ftam_req.tid.core    <= CORENO;
        ftam_req.tid.channel <= CID;
        ftam_req.tid.tranid  <= tranid;
        tranid <= tranid == 4'd15 ? ARB_TRANID_FIRST : tranid + 4'd1;
        last   <= grant[0] ? OWN_D : OWN_I;
      end
      cnt <= cnt + 4'(acc) - 4'(rsp_hit) - 4'(tmo_fire);
      for (int k = 0; k < 16; k++)
        if (acc && tranid == 4'(k))
          tbl[k] <= '{valid: 1'b1, owner: (grant[0] ? OWN_D : OWN_I), age: 8'd0};
        else if ((rsp_hit && rsp_idx == 4'(k)) || (tmo_fire && tmo_idx == 4'(k)))
          tbl[k] <= '0;
`ifdef RF80386_ARB_TIMEOUT_EN
        else if (tbl[k].valid && tbl[k].age != 8'hff)
          tbl[k].age <= tbl[k].age + 8'd1;
`endif
    end
endmodule

// File: tb/tb_rf80386_bus_arbiter.sv
// tb_rf80386_bus_arbiter: directed checks of arbitration, tranid tagging, routing and reset.
module tb_rf80386_bus_arbiter;
  import fta_bus_pkg::*;
  logic clk, rst_n;
  fta_cmd_request128_t  d_req, i_req, ftam_req;
  fta_cmd_response128_t d_resp, i_resp, ftam_resp;
  logic d_acc, i_acc, busy;
  int total, bad;
  rf80386_bus_arbiter #(.CORENO(6'd1), .CID(3'd1), .MAX_OUT(4), .TMO_CYCLES(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .d_req_i(d_req), .d_accept_o(d_acc), .d_resp_o(d_resp),
    .i_req_i(i_req), .i_accept_o(i_acc), .i_resp_o(i_resp),
    .ftam_req(ftam_req), .ftam_resp(ftam_resp), .busy_o(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic fta_cmd_request128_t mk(input logic [31:0] a, input logic w);
    mk = '0;
    mk.cyc = 1'b1;
    mk.stb = 1'b1;
    mk.we  = w;
    mk.sel = '1;
    mk.adr = a;
    mk.dat = {4{a}};
  endfunction
  function automatic fta_cmd_response128_t ak(input logic [3:0] t, input logic [2:0] ch);
    ak = '0;
    ak.tid.core    = 6'd1;
    ak.tid.channel = ch;
    ak.tid.tranid  = t;
    ak.ack         = 1'b1;
    ak.dat         = {124'h0, t};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    d_req = '0;
    i_req = '0;
    ftam_resp = '0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    d_req = '0;
    i_req = mk(32'h100, 1'b0);
    ftam_resp = ak(4'd1, 3'd1);
    tick;
    tick;
    total++; if (i_acc !== 1'b0 || d_acc !== 1'b0) begin bad++; $display("FAIL reset_acc got=%b%b exp=00", i_acc, d_acc); end
    total++; if (ftam_req !== '0) begin bad++; $display("FAIL reset_ftam got=%h exp=0", ftam_req); end
    total++; if (d_resp !== '0 || i_resp !== '0 || busy !== 1'b0) begin bad++; $display("FAIL reset_resp got_busy=%b d_ack=%b i_ack=%b exp=0", busy, d_resp.ack, i_resp.ack); end
    i_req = '0;
    ftam_resp = '0;
    rst_n = 1'b1;
  endtask
  task automatic test_single_iread;
    do_reset;
    i_req = mk(32'h100, 1'b0);
    #2;
    total++; if (i_acc !== 1'b1 || d_acc !== 1'b0) begin bad++; $display("FAIL single_acc got=%b%b exp=10", i_acc, d_acc); end
    tick;
    i_req = '0;
    total++; if (ftam_req.cyc !== 1'b1 || ftam_req.tid.tranid !== 4'd1 || ftam_req.adr !== 32'h100 || ftam_req.tid.core !== 6'd1 || ftam_req.tid.channel !== 3'd1)
      begin bad++; $display("FAIL single_issue got cyc=%b tid=%h adr=%h exp cyc=1 tranid=1 adr=100", ftam_req.cyc, ftam_req.tid, ftam_req.adr); end
    tick;
    total++; if (ftam_req.cyc !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_onecycle got cyc=%b busy=%b exp cyc=0 busy=1", ftam_req.cyc, busy); end
    ftam_resp = ak(4'd1, 3'd1);
    #2;
    total++; if (i_resp !== ak(4'd1, 3'd1) || d_resp !== '0) begin bad++; $display("FAIL single_route got i_ack=%b d_ack=%b exp i_ack=1 d_ack=0", i_resp.ack, d_resp.ack); end
    tick;
    ftam_resp = '0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy got=%b exp=0", busy); end
  endtask
  task automatic test_alternate;
    do_reset;
    d_req = mk(32'h200, 1'b0);
    i_req = mk(32'h300, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #2;
      total++; if ({i_acc, d_acc} !== (k % 2 == 0 ? 2'b01 : 2'b10)) begin bad++; $display("FAIL alt_grant%0d got=%b%b exp=%b", k, i_acc, d_acc, (k % 2 == 0 ? 2'b01 : 2'b10)); end
      if (k > 0) begin
        total++; if ((k % 2 == 1 ? d_resp.ack : i_resp.ack) !== 1'b1 || (k % 2 == 1 ? i_resp.ack : d_resp.ack) !== 1'b0)
          begin bad++; $display("FAIL alt_route%0d got d_ack=%b i_ack=%b", k, d_resp.ack, i_resp.ack); end
      end
      tick;
      total++; if (ftam_req.tid.tranid !== 4'(k + 1) || ftam_req.adr !== (k % 2 == 0 ? 32'h200 : 32'h300))
        begin bad++; $display("FAIL alt_issue%0d got tranid=%0d adr=%h exp tranid=%0d", k, ftam_req.tid.tranid, ftam_req.adr, k + 1); end
      ftam_resp = ak(4'(k + 1), 3'd1);
    end
    #2;
    total++; if (i_resp.ack !== 1'b1 || i_resp.tid.tranid !== 4'd4 || d_resp.ack !== 1'b0) begin bad++; $display("FAIL alt_route4 got i_ack=%b tid=%0d d_ack=%b exp 1 4 0", i_resp.ack, i_resp.tid.tranid, d_resp.ack); end
    d_req = '0;
    i_req = '0;
    tick;
    ftam_resp = '0;
  endtask
  task automatic test_write_prio;
    do_reset;
    d_req = mk(32'h400, 1'b0);
    #2;
    total++; if (d_acc !== 1'b1) begin bad++; $display("FAIL wp_first got=%b exp=1", d_acc); end
    tick;
    d_req = mk(32'h404, 1'b1);
    i_req = mk(32'h500, 1'b0);
    #2;
    total++; if ({i_acc, d_acc} !== 2'b01) begin bad++; $display("FAIL wp_override got=%b%b exp=01", i_acc, d_acc); end
    tick;
    d_req = '0;
    total++; if (ftam_req.we !== 1'b1 || ftam_req.adr !== 32'h404) begin bad++; $display("FAIL wp_issue got we=%b adr=%h exp we=1 adr=404", ftam_req.we, ftam_req.adr); end
    #2;
    total++; if (i_acc !== 1'b1) begin bad++; $display("FAIL wp_i_next got=%b exp=1", i_acc); end
    tick;
    i_req = '0;
    total++; if (ftam_req.adr !== 32'h500 || ftam_req.tid.tranid !== 4'd3) begin bad++; $display("FAIL wp_i_issue got adr=%h tranid=%0d exp 500 3", ftam_req.adr, ftam_req.tid.tranid); end
  endtask
  task automatic test_max_out;
    int n;
    do_reset;
    n = 0;
    d_req = mk(32'h600, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #2;
      n += int'(d_acc);
      tick;
    end
    total++; if (n !== 4) begin bad++; $display("FAIL max_fill got=%0d exp=4", n); end
    #2;
    total++; if (d_acc !== 1'b0) begin bad++; $display("FAIL max_block got=%b exp=0", d_acc); end
    tick;
    ftam_resp = ak(4'd2, 3'd1);
    #2;
    total++; if (d_resp.ack !== 1'b1 || d_resp.tid.tranid !== 4'd2 || d_acc !== 1'b0) begin bad++; $display("FAIL max_ack got ack=%b tid=%0d acc=%b exp 1 2 0", d_resp.ack, d_resp.tid.tranid, d_acc); end
    tick;
    ftam_resp = '0;
    #2;
    total++; if (d_acc !== 1'b1) begin bad++; $display("FAIL max_reaccept got=%b exp=1", d_acc); end
    tick;
    d_req = '0;
    total++; if (ftam_req.tid.tranid !== 4'd5) begin bad++; $display("FAIL max_tranid got=%0d exp=5", ftam_req.tid.tranid); end
  endtask
  task automatic test_ooo;
    do_reset;
    d_req = mk(32'h700, 1'b0);
    tick;
    d_req = '0;
    i_req = mk(32'h800, 1'b0);
    tick;
    i_req = mk(32'h810, 1'b0);
    tick;
    i_req = '0;
    ftam_resp = ak(4'd3, 3'd1);
    #2;
    total++; if (i_resp.ack !== 1'b1 || i_resp.tid.tranid !== 4'd3 || d_resp.ack !== 1'b0) begin bad++; $display("FAIL ooo_t3 got i_ack=%b tid=%0d d_ack=%b exp 1 3 0", i_resp.ack, i_resp.tid.tranid, d_resp.ack); end
    tick;
    ftam_resp = ak(4'd1, 3'd1);
    #2;
    total++; if (d_resp.ack !== 1'b1 || d_resp.tid.tranid !== 4'd1 || i_resp.ack !== 1'b0) begin bad++; $display("FAIL ooo_t1 got d_ack=%b tid=%0d i_ack=%b exp 1 1 0", d_resp.ack, d_resp.tid.tranid, i_resp.ack); end
    tick;
    ftam_resp = ak(4'd2, 3'd2);
    #2;
    total++; if (d_resp !== '0 || i_resp !== '0) begin bad++; $display("FAIL ooo_foreign got d_ack=%b i_ack=%b exp 0 0", d_resp.ack, i_resp.ack); end
    tick;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ooo_busy got=%b exp=1", busy); end
    ftam_resp = ak(4'd2, 3'd1);
    #2;
    total++; if (i_resp.ack !== 1'b1 || i_resp.tid.tranid !== 4'd2) begin bad++; $display("FAIL ooo_t2 got i_ack=%b tid=%0d exp 1 2", i_resp.ack, i_resp.tid.tranid); end
    tick;
    ftam_resp = '0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ooo_idle got=%b exp=0", busy); end
  endtask
  task automatic test_reset_mid;
    do_reset;
    i_req = mk(32'h900, 1'b0);
    tick;
    i_req = '0;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (ftam_req !== '0 || busy !== 1'b0 || i_acc !== 1'b0) begin bad++; $display("FAIL mid_reset got cyc=%b busy=%b exp 0 0", ftam_req.cyc, busy); end
    tick;
    rst_n = 1'b1;
    ftam_resp = ak(4'd1, 3'd1);
    #2;
    total++; if (i_resp !== '0 || d_resp !== '0) begin bad++; $display("FAIL mid_late got i_ack=%b d_ack=%b exp 0 0", i_resp.ack, d_resp.ack); end
    tick;
    ftam_resp = '0;
  endtask
`ifdef RF80386_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    d_req = mk(32'ha00, 1'b0);
    tick;
    d_req = '0;
    for (int k = 0; k < 7; k++) tick;
    total++; if (d_resp.rty !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", d_resp.rty); end
    tick;
    total++; if (d_resp.rty !== 1'b1 || d_resp.ack !== 1'b0 || d_resp.dat !== '0 || d_resp.tid.tranid !== 4'd1)
      begin bad++; $display("FAIL tmo_fire got rty=%b ack=%b tid=%0d exp 1 0 1", d_resp.rty, d_resp.ack, d_resp.tid.tranid); end
    tick;
    total++; if (d_resp.rty !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL tmo_once got rty=%b busy=%b exp 0 0", d_resp.rty, busy); end
    ftam_resp = ak(4'd1, 3'd1);
    #2;
    total++; if (d_resp !== '0) begin bad++; $display("FAIL tmo_late got ack=%b exp 0", d_resp.ack); end
    tick;
    ftam_resp = '0;
  endtask
`endif
  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_single_iread;
    test_alternate;
    test_write_prio;
    test_max_out;
    test_ooo;
    test_reset_mid;
`ifdef RF80386_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
